// File: rtl/mem_access_unit_pkg.sv
// Shared widths and FSM encoding for the memory access stage.
package mem_access_unit_pkg;

    localparam int unsigned PROC_DATA_WIDTH_DEF        = 16;
    localparam int unsigned PROC_REGFILE_LOG2_DEEP_DEF = 5;
    localparam int unsigned INSTMEM_LOG2_DEEP_DEF      = 8;
    localparam int unsigned DMEM_LOG2_DEEP_DEF         = 8;
    localparam int unsigned DMEM_TIMEOUT_DEF           = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mau_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter bounding how long an access may sit in REQ or WAIT.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags the last allowed waiting cycle; the owner only acts on it while counting.
    assign expired_c_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: passes ALU results through, or runs one data-memory access per bundle.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned PROC_DATA_WIDTH        = PROC_DATA_WIDTH_DEF,
    parameter int unsigned PROC_REGFILE_LOG2_DEEP = PROC_REGFILE_LOG2_DEEP_DEF,
    parameter int unsigned INSTMEM_LOG2_DEEP      = INSTMEM_LOG2_DEEP_DEF,
    parameter int unsigned DMEM_LOG2_DEEP         = DMEM_LOG2_DEEP_DEF,
    parameter int unsigned DMEM_TIMEOUT           = DMEM_TIMEOUT_DEF
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              valid_i,
    input  logic                              reg_write_en_i,
    input  logic                              mem_write_en_i,
    input  logic                              mem_read_en_i,
    input  logic                              mem_to_reg_i,
    input  logic [PROC_DATA_WIDTH-1:0]        alu_i,
    input  logic [PROC_DATA_WIDTH-1:0]        reg_data2_i,
    input  logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i,
    input  logic [1:0]                        thread_id_i,
    input  logic [INSTMEM_LOG2_DEEP-1:0]      pc_carry_baggage_i,
    output logic                              stall_o,
    output logic                              dmem_req_o,
    output logic                              dmem_we_o,
    output logic [DMEM_LOG2_DEEP-1:0]         dmem_addr_o,
    output logic [PROC_DATA_WIDTH-1:0]        dmem_wdata_o,
    input  logic                              dmem_gnt_i,
    input  logic                              dmem_rvalid_i,
    input  logic [PROC_DATA_WIDTH-1:0]        dmem_rdata_i,
    output logic                              wb_valid_o,
    output logic                              wb_reg_write_en_o,
    output logic [PROC_REGFILE_LOG2_DEEP-1:0] wb_reg_write_addr_o,
    output logic [PROC_DATA_WIDTH-1:0]        wb_data_o,
    output logic [1:0]                        wb_thread_id_o,
    output logic [INSTMEM_LOG2_DEEP-1:0]      wb_pc_carry_baggage_o,
    output logic                              err_o
);

    mau_state_e state_q, state_d;

    logic [PROC_DATA_WIDTH-1:0]        hold_alu_q, hold_wdata_q;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] hold_waddr_q;
    logic                              hold_reg_we_q, hold_mem_we_q, hold_m2r_q;
    logic [1:0]                        hold_tid_q;
    logic [INSTMEM_LOG2_DEEP-1:0]      hold_pc_q;

    logic                              wb_valid_q, wb_valid_d;
    logic                              wb_reg_we_q, wb_reg_we_d;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] wb_waddr_q, wb_waddr_d;
    logic [PROC_DATA_WIDTH-1:0]        wb_data_q, wb_data_d;
    logic [1:0]                        wb_tid_q, wb_tid_d;
    logic [INSTMEM_LOG2_DEEP-1:0]      wb_pc_q, wb_pc_d;
    logic                              err_q, err_d;

    logic                              capture_c, retire_c, retire_we_c;
    logic [PROC_DATA_WIDTH-1:0]        retire_data_c;
    logic                              tmo_clear_c, tmo_enable_c, tmo_expired_c;

    mem_timeout_ctr #(
        .TIMEOUT (DMEM_TIMEOUT)
    ) u_timeout (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (tmo_clear_c),
        .enable_i    (tmo_enable_c),
        .expired_c_o (tmo_expired_c)
    );

    // Next state, counter control and writeback selection.
    always_comb begin
        state_d       = state_q;
        capture_c     = 1'b0;
        retire_c      = 1'b0;
        retire_we_c   = hold_reg_we_q;
        retire_data_c = hold_alu_q;
        tmo_clear_c   = 1'b0;
        tmo_enable_c  = 1'b0;
        err_d         = 1'b0;
        wb_valid_d    = 1'b0;
        wb_reg_we_d   = wb_reg_we_q;
        wb_waddr_d    = wb_waddr_q;
        wb_data_d     = wb_data_q;
        wb_tid_d      = wb_tid_q;
        wb_pc_d       = wb_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (mem_write_en_i || mem_read_en_i) begin
                        capture_c   = 1'b1;
                        tmo_clear_c = 1'b1;
                        state_d     = ST_REQ;
                    end else begin
                        wb_valid_d  = 1'b1;
                        wb_reg_we_d = reg_write_en_i;
                        wb_waddr_d  = reg_write_addr_i;
                        wb_data_d   = alu_i;
                        wb_tid_d    = thread_id_i;
                        wb_pc_d     = pc_carry_baggage_i;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_gnt_i) begin
                    if (hold_mem_we_q) begin
                        retire_c = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        tmo_clear_c = 1'b1;
                        state_d     = ST_WAIT;
                    end
                end else begin
                    tmo_enable_c = 1'b1;
                    if (tmo_expired_c) begin
                        retire_c      = 1'b1;
                        retire_we_c   = 1'b0;
                        retire_data_c = '0;
                        err_d         = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid_i) begin
                    retire_c      = 1'b1;
                    retire_data_c = hold_m2r_q ? dmem_rdata_i : hold_alu_q;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_enable_c = 1'b1;
                    if (tmo_expired_c) begin
                        retire_c      = 1'b1;
                        retire_we_c   = 1'b0;
                        retire_data_c = '0;
                        err_d         = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (retire_c) begin
            wb_valid_d  = 1'b1;
            wb_reg_we_d = retire_we_c;
            wb_waddr_d  = hold_waddr_q;
            wb_data_d   = retire_data_c;
            wb_tid_d    = hold_tid_q;
            wb_pc_d     = hold_pc_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding registers for the bundle that owns the memory port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_alu_q    <= '0;
            hold_wdata_q  <= '0;
            hold_waddr_q  <= '0;
            hold_reg_we_q <= 1'b0;
            hold_mem_we_q <= 1'b0;
            hold_m2r_q    <= 1'b0;
            hold_tid_q    <= '0;
            hold_pc_q     <= '0;
        end else if (capture_c) begin
            hold_alu_q    <= alu_i;
            hold_wdata_q  <= reg_data2_i;
            hold_waddr_q  <= reg_write_addr_i;
            hold_reg_we_q <= reg_write_en_i;
            hold_mem_we_q <= mem_write_en_i;
            hold_m2r_q    <= mem_to_reg_i;
            hold_tid_q    <= thread_id_i;
            hold_pc_q     <= pc_carry_baggage_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_q  <= 1'b0;
            wb_reg_we_q <= 1'b0;
            wb_waddr_q  <= '0;
            wb_data_q   <= '0;
            wb_tid_q    <= '0;
            wb_pc_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            wb_reg_we_q <= wb_reg_we_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_data_q   <= wb_data_d;
            wb_tid_q    <= wb_tid_d;
            wb_pc_q     <= wb_pc_d;
            err_q       <= err_d;
        end
    end

    assign stall_o               = (state_q != ST_IDLE);
    assign dmem_req_o            = (state_q == ST_REQ);
    assign dmem_we_o             = (state_q == ST_REQ) && hold_mem_we_q;
    assign dmem_addr_o           = hold_alu_q[DMEM_LOG2_DEEP-1:0];
    assign dmem_wdata_o          = hold_wdata_q;
    assign wb_valid_o            = wb_valid_q;
    assign wb_reg_write_en_o     = wb_reg_we_q;
    assign wb_reg_write_addr_o   = wb_waddr_q;
    assign wb_data_o             = wb_data_q;
    assign wb_thread_id_o        = wb_tid_q;
    assign wb_pc_carry_baggage_o = wb_pc_q;
    assign err_o                 = err_q;

endmodule
